// File: rtl/reg_file_pkg.sv
// Shared constants for the multi-port register file: default sizes and the
// rule that decides which write port wins when two ports target one register.
package reg_file_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;

  // Highest-index write port wins an address collision (port 1 over port 0).
  localparam bit WR_HIGH_WINS = 1'b1;

  // Maps a loop step to a port index so later steps override earlier ones.
  function automatic int wr_port_order(input int step, input int num_wr);
    return WR_HIGH_WINS ? step : (num_wr - 1 - step);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set on issue, cleared on
// writeback, flushed in bulk; read ports see the registered value only.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_WR   = 1,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Clears are applied before the set so a new producer supersedes a retiring one.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p]) busy_d[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
      end
      if (iss_en) busy_d[iss_addr] = 1'b1;
    end
    if (ZERO_REG) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    rd_busy = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      rd_busy[r] = busy_q[rd_addr[r*ADDR_W +: ADDR_W]];
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with optional zero register, optional same-cycle
// write-to-read bypass and an integrated busy scoreboard for RAW detection.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic [ADDR_W-1:0] wa;
  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rv;
  int                pw;
  int                pb;

  always_comb begin
    regs_d = regs_q;
    wa     = '0;
    pw     = 0;
    for (int s = 0; s < NUM_WR; s++) begin
      pw = wr_port_order(s, NUM_WR);
      wa = wr_addr[pw*ADDR_W +: ADDR_W];
      if (wr_en[pw] && !(ZERO_REG && (wa == '0))) begin
        regs_d[wa] = wr_data[pw*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Bypass follows the same port priority as the write itself.
  always_comb begin
    rd_data = '0;
    ra      = '0;
    rv      = '0;
    pb      = 0;
    for (int r = 0; r < NUM_RD; r++) begin
      ra = rd_addr[r*ADDR_W +: ADDR_W];
      rv = regs_q[ra];
      if (BYPASS) begin
        for (int s = 0; s < NUM_WR; s++) begin
          pb = wr_port_order(s, NUM_WR);
          if (wr_en[pb] && (wr_addr[pb*ADDR_W +: ADDR_W] == ra)) begin
            rv = wr_data[pb*DATA_W +: DATA_W];
          end
        end
      end
      if (ZERO_REG && (ra == '0)) rv = '0;
      rd_data[r*DATA_W +: DATA_W] = rv;
    end
  end

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (dual-write with bypass, single-write
// without bypass) checked each cycle against an array model, plus directed cases.
module tb_reg_file_mp;

  logic        clk;
  logic        rst_n;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [9:0]  rd_addr;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        flush;

  logic [63:0] rd_data_a;
  logic [1:0]  rd_busy_a;
  logic [63:0] rd_data_b;
  logic [1:0]  rd_busy_b;

  int checks;
  int failures;

  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  bit          busy_a [32];
  bit          busy_b [32];

  reg_file_mp #(
    .DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
  );

  reg_file_mp #(
    .DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(1), .ZERO_REG(1'b1), .BYPASS(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[4:0]), .wr_data(wr_data[31:0]),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: a write to r0 never lands, the last enabled port wins,
  // flush beats issue, issue beats writeback clear, r0 is never busy.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        mem_a[i] = '0; mem_b[i] = '0; busy_a[i] = 0; busy_b[i] = 0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (wr_en[p] && wr_addr[p*5 +: 5] != 0) mem_a[wr_addr[p*5 +: 5]] = wr_data[p*32 +: 32];
      end
      if (wr_en[0] && wr_addr[4:0] != 0) mem_b[wr_addr[4:0]] = wr_data[31:0];
      if (flush) begin
        for (int i = 0; i < 32; i++) begin busy_a[i] = 0; busy_b[i] = 0; end
      end else begin
        for (int p = 0; p < 2; p++) if (wr_en[p]) busy_a[wr_addr[p*5 +: 5]] = 0;
        if (wr_en[0]) busy_b[wr_addr[4:0]] = 0;
        if (iss_en && iss_addr != 0) begin busy_a[iss_addr] = 1; busy_b[iss_addr] = 1; end
      end
    end
  end

  function automatic logic [31:0] exp_rd_a(input logic [4:0] a);
    logic [31:0] v;
    if (a == 0) return 32'h0;
    v = mem_a[a];
    if (wr_en[0] && wr_addr[4:0] == a) v = wr_data[31:0];
    if (wr_en[1] && wr_addr[9:5] == a) v = wr_data[63:32];
    return v;
  endfunction

  function automatic logic [31:0] exp_rd_b(input logic [4:0] a);
    return (a == 0) ? 32'h0 : mem_b[a];
  endfunction

  always @(negedge clk) begin
    for (int r = 0; r < 2; r++) begin
      chk($sformatf("a_rd_data%0d", r), rd_data_a[r*32 +: 32], exp_rd_a(rd_addr[r*5 +: 5]));
      chk($sformatf("b_rd_data%0d", r), rd_data_b[r*32 +: 32], exp_rd_b(rd_addr[r*5 +: 5]));
      chk($sformatf("a_rd_busy%0d", r), {31'b0, rd_busy_a[r]}, {31'b0, busy_a[rd_addr[r*5 +: 5]]});
      chk($sformatf("b_rd_busy%0d", r), {31'b0, rd_busy_b[r]}, {31'b0, busy_b[rd_addr[r*5 +: 5]]});
    end
  end

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; iss_en = 0; iss_addr = '0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 0;
    idle();
    rd_addr = {5'd5, 5'd0};
    repeat (3) tick();
    rst_n = 1;
    tick();

    chk("reset_rd0_r0", rd_data_a[31:0], 32'h0);
    chk("reset_rd1_r5", rd_data_a[63:32], 32'h0);
    rd_addr = {5'd5, 5'd31};
    #1;
    chk("reset_rd0_r31", rd_data_a[31:0], 32'h0);
    chk("reset_busy", {30'b0, rd_busy_a}, 32'h0);

    // Write r7 with a same-cycle read: bypass instance forwards, the other does not.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'hDEADBEEF};
    rd_addr = {5'd0, 5'd7};
    #1;
    chk("bypass_same_cycle", rd_data_a[31:0], 32'hDEADBEEF);
    chk("nobypass_same_cycle", rd_data_b[31:0], 32'h0);
    tick(); idle();
    chk("bypass_after_edge", rd_data_a[31:0], 32'hDEADBEEF);
    chk("nobypass_after_edge", rd_data_b[31:0], 32'hDEADBEEF);

    // r0 ignores writes and issues.
    wr_en = 2'b01; wr_addr = '0; wr_data = {32'h0, 32'h1234};
    iss_en = 1; iss_addr = 0; rd_addr = '0;
    #1;
    chk("zero_bypass", rd_data_a[31:0], 32'h0);
    tick(); idle();
    chk("zero_rd", rd_data_a[31:0], 32'h0);
    chk("zero_busy", {31'b0, rd_busy_a[0]}, 32'h0);
    tick();
    chk("zero_rd_later", rd_data_b[31:0], 32'h0);

    // Both ports target r3: port 1 wins in storage and on the bypass.
    wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'h5555, 32'hAAAA};
    rd_addr = {5'd0, 5'd3};
    #1;
    chk("dual_bypass", rd_data_a[31:0], 32'h5555);
    tick(); idle();
    chk("dual_stored", rd_data_a[31:0], 32'h5555);
    chk("single_port0_stored", rd_data_b[31:0], 32'hAAAA);

    // Scoreboard on r9.
    iss_en = 1; iss_addr = 9; rd_addr = {5'd9, 5'd9};
    #1;
    chk("busy_not_yet", {31'b0, rd_busy_a[1]}, 32'h0);
    tick(); idle();
    chk("busy_set", {31'b0, rd_busy_a[1]}, 32'h1);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h99}; iss_en = 1; iss_addr = 9;
    tick(); idle();
    chk("busy_set_wins", {31'b0, rd_busy_a[1]}, 32'h1);
    wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h77, 32'h0};
    #1;
    chk("busy_no_bypass", {31'b0, rd_busy_a[1]}, 32'h1);
    tick(); idle();
    chk("busy_cleared", {31'b0, rd_busy_a[1]}, 32'h0);
    chk("r9_port1_data", rd_data_a[63:32], 32'h77);

    // Flush clears r4 and r6.
    iss_en = 1; iss_addr = 4; tick();
    iss_en = 1; iss_addr = 6; tick(); idle();
    rd_addr = {5'd6, 5'd4};
    #1;
    chk("preflush_busy", {30'b0, rd_busy_a}, 32'h3);
    flush = 1; iss_en = 1; iss_addr = 4;
    tick(); idle();
    chk("flush_busy", {30'b0, rd_busy_a}, 32'h0);

    // Randomized traffic; addresses biased low to provoke collisions.
    for (int n = 0; n < 1500; n++) begin
      wr_en    = 2'($urandom_range(0, 3));
      wr_addr  = {5'($urandom_range(0, 7) == 0 ? 31 : $urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_data  = {$urandom(), $urandom()};
      iss_en   = 1'($urandom_range(0, 1));
      iss_addr = 5'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 31) == 0);
      rd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      tick();
    end
    idle();

    // Asynchronous reset between edges.
    wr_en = 2'b01; wr_addr = {5'd0, 5'd12}; wr_data = {32'h0, 32'hFF};
    iss_en = 1; iss_addr = 12; tick(); idle();
    rd_addr = {5'd12, 5'd12};
    #1;
    chk("pre_reset_data", rd_data_a[31:0], 32'hFF);
    chk("pre_reset_busy", {31'b0, rd_busy_a[1]}, 32'h1);
    rst_n = 0;
    #1;
    chk("async_reset_data", rd_data_a[31:0], 32'h0);
    chk("async_reset_data_b", rd_data_b[63:32], 32'h0);
    chk("async_reset_busy", {30'b0, rd_busy_a}, 32'h0);
    tick();
    rst_n = 1;
    tick(); tick();
    chk("post_reset_data", rd_data_a[31:0], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
